// File: rtl/sdm_pkg.sv
// sdm_pkg -- shared definitions for the second-order sigma-delta modulator.
//
// Contents:
//   sdm_state_t : modulator control states (IDLE, RUN)
//   FB_SHIFT    : feedback shift for the default 16-bit PCM / 5-bit code setup
//   QMAX        : largest magnitude the quantizer may emit
//   SAT_W       : width of the wide arithmetic domain used for saturation
//   sat_add()   : signed add clipped symmetrically to +/-limit

package sdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sdm_state_t;

  localparam int FB_SHIFT = 11;
  localparam int QMAX     = 15;
  localparam int SAT_W    = 64;

  // Operands arrive already sign-extended to SAT_W, so the raw sum cannot wrap
  // for any integrator width the modulator is built with.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input logic signed [SAT_W-1:0] limit
  );
    logic signed [SAT_W-1:0] sum;
    sum = a + b;
    if (sum > limit) begin
      return limit;
    end else if (sum < -limit) begin
      return -limit;
    end
    return sum;
  endfunction

endpackage

// File: rtl/sigma_delta_modulator_quantizer.sv
// sdm_quantizer -- combinational multi-level quantizer for the modulator.
//
// Rounds the second integrator to the nearest multiple of 2^FB_SHIFT and
// clamps the resulting code to [-QMAX, +QMAX].
//
// Ports:
//   acc : second integrator value (signed, ACC_WIDTH bits)
//   q   : quantized code (signed, OUTPUT_WIDTH bits)

module sdm_quantizer
  import sdm_pkg::*;
#(
  parameter int ACC_WIDTH    = 28,
  parameter int FB_SHIFT     = sdm_pkg::FB_SHIFT,
  parameter int OUTPUT_WIDTH = 5
) (
  input  logic signed [ACC_WIDTH-1:0]    acc,
  output logic signed [OUTPUT_WIDTH-1:0] q
);

  // One extra bit keeps the rounding offset from overflowing at full scale.
  localparam int SW = ACC_WIDTH + 1;
  localparam logic signed [SW-1:0] HALF = SW'(2 ** (FB_SHIFT - 1));
  localparam logic signed [SW-1:0] QHI  = SW'(QMAX);
  localparam logic signed [SW-1:0] QLO  = -QHI;

  logic signed [SW-1:0] acc_ext;
  logic signed [SW-1:0] rounded;
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] clamped;

  // Arithmetic right shift gives floor(), so adding half first rounds to nearest
  // with ties going toward +infinity.
  always_comb begin
    acc_ext = {acc[ACC_WIDTH-1], acc};
    rounded = acc_ext + HALF;
    shifted = rounded >>> FB_SHIFT;
    clamped = shifted;
    if (shifted > QHI) begin
      clamped = QHI;
    end else if (shifted < QLO) begin
      clamped = QLO;
    end
    q = OUTPUT_WIDTH'(clamped);
  end

endmodule

// File: rtl/sigma_delta_modulator.sv
// sigma_delta_modulator -- second-order multi-bit sigma-delta modulator.
//
// Accepts one signed PCM sample per OSR clocks through a one-entry holding
// register and produces a registered signed modulator code every clock while
// running. Noise transfer function is (1 - z^-1)^2.
//
// Ports:
//   clk       : modulator clock
//   rst_n     : synchronous active-low reset
//   en        : run enable
//   pcm_valid : PCM sample offered
//   pcm_ready : holding register empty
//   pcm_data  : signed PCM sample
//   out_valid : out_data valid this clock
//   out_data  : signed modulator code in [-QMAX, +QMAX]
//   underrun  : one-clock pulse, no fresh sample at a phase boundary
//   overload  : one-clock pulse, integrators cleared after |i2| overload

module sigma_delta_modulator
  import sdm_pkg::*;
#(
  parameter int PCM_WIDTH    = 16,
  parameter int OUTPUT_WIDTH = 5,
  parameter int OSR          = 64,
  parameter int ACC_WIDTH    = 28,
  parameter int OVL_LIMIT    = 2 ** 21
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           pcm_valid,
  output logic                           pcm_ready,
  input  logic signed [PCM_WIDTH-1:0]    pcm_data,
  output logic                           out_valid,
  output logic signed [OUTPUT_WIDTH-1:0] out_data,
  output logic                           underrun,
  output logic                           overload
);

  localparam int SHIFT_BITS = PCM_WIDTH - OUTPUT_WIDTH;
  localparam int PHASE_W    = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OSR - 1);

  localparam logic signed [SAT_W-1:0] ACC_MAX =
    (SAT_W'(1) <<< (ACC_WIDTH - 1)) - SAT_W'(1);
  localparam logic signed [SAT_W-1:0] OVL_W = SAT_W'(OVL_LIMIT);

  sdm_state_t state;
  sdm_state_t state_next;

  logic                        hold_full;
  logic signed [PCM_WIDTH-1:0] hold_data;
  logic signed [PCM_WIDTH-1:0] x;
  logic [PHASE_W-1:0]          phase;
  logic signed [ACC_WIDTH-1:0] i1;
  logic signed [ACC_WIDTH-1:0] i2;

  logic signed [OUTPUT_WIDTH-1:0] q;

  logic signed [SAT_W-1:0] i1_w;
  logic signed [SAT_W-1:0] i2_w;
  logic signed [SAT_W-1:0] xs_w;
  logic signed [SAT_W-1:0] q_w;
  logic signed [SAT_W-1:0] fb_w;
  logic signed [SAT_W-1:0] i1_sum;
  logic signed [SAT_W-1:0] i2_sum;

  logic run_active;
  logic start;
  logic boundary;
  logic xfer;
  logic ovl;

  // Quantizer always looks at the current (pre-update) second integrator.
  sdm_quantizer #(
    .ACC_WIDTH    (ACC_WIDTH),
    .FB_SHIFT     (SHIFT_BITS),
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_quantizer (
    .acc (i2),
    .q   (q)
  );

  assign pcm_ready = ~hold_full;

  // The holding register only accepts while empty, so a PCM transfer can never
  // coincide with a boundary or start load, both of which need it full.
  assign xfer       = pcm_valid && !hold_full;
  assign run_active = (state == RUN) && en;
  assign start      = (state == IDLE) && en && hold_full;
  assign boundary   = run_active && (phase == PHASE_LAST);

  // Everything is widened to SAT_W so the two-term updates cannot wrap before
  // saturation is applied.
  assign i1_w = {{(SAT_W - ACC_WIDTH){i1[ACC_WIDTH-1]}}, i1};
  assign i2_w = {{(SAT_W - ACC_WIDTH){i2[ACC_WIDTH-1]}}, i2};
  assign xs_w = {{(SAT_W - PCM_WIDTH){x[PCM_WIDTH-1]}}, x};
  assign q_w  = {{(SAT_W - OUTPUT_WIDTH){q[OUTPUT_WIDTH-1]}}, q};
  assign fb_w = q_w <<< SHIFT_BITS;

  assign i1_sum = sat_add(i1_w, xs_w - fb_w, ACC_MAX);
  assign i2_sum = sat_add(i2_w, i1_w - (fb_w <<< 1), ACC_MAX);

  assign ovl = (i2_w > OVL_W) || (i2_w < -OVL_W);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en && hold_full) state_next = RUN;
      RUN:  if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      x         <= '0;
      phase     <= '0;
      i1        <= '0;
      i2        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      underrun  <= 1'b0;
      overload  <= 1'b0;
    end else begin
      state    <= state_next;
      underrun <= 1'b0;
      overload <= 1'b0;

      if (xfer) begin
        hold_data <= pcm_data;
        hold_full <= 1'b1;
      end else if (start || (boundary && hold_full)) begin
        hold_full <= 1'b0;
      end

      // A missing sample at the boundary keeps x, so the modulator repeats it.
      if (start || (boundary && hold_full)) begin
        x <= hold_data;
      end

      if (boundary && !hold_full) begin
        underrun <= 1'b1;
      end

      // Leaving RUN (or sitting in IDLE) zeroes the loop and the output in the
      // same edge, so the clock after en drops already shows idle values.
      if (run_active) begin
        phase     <= boundary ? '0 : phase + 1'b1;
        out_data  <= q;
        out_valid <= 1'b1;
        if (ovl) begin
          i1       <= '0;
          i2       <= '0;
          overload <= 1'b1;
        end else begin
          i1 <= ACC_WIDTH'(i1_sum);
          i2 <= ACC_WIDTH'(i2_sum);
        end
      end else begin
        phase     <= '0;
        out_data  <= '0;
        out_valid <= 1'b0;
        i1        <= '0;
        i2        <= '0;
      end
    end
  end

endmodule
